// File: rtl/layer_buffer.sv
// Double-buffered neuron layer storage: one bank feeds the current layer while the
// other collects its results; a handshake swaps the roles once the output bank is full.
module layer_buffer #(
    parameter int N      = 4,
    parameter int WIDTH  = 16,
    parameter int LAYERS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_enable,
    input  logic [$clog2(N)-1:0]         write_address,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         load_enable,
    input  logic [$clog2(N)-1:0]         load_address,
    input  logic [WIDTH-1:0]             load_data,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic [N*WIDTH-1:0]           out_data,
    output logic [$clog2(N+1)-1:0]       written_count,
    output logic                         bank_full,
    output logic                         bank_sel,
    output logic [$clog2(LAYERS+1)-1:0]  layer_idx,
    output logic                         done,
    output logic                         addr_err
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int LW = $clog2(LAYERS + 1);

    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] layer_q, layer_d;
    logic          bank_sel_q, ack_q, done_q, done_d, err_q, err_d;
    logic          wr_ok, ld_ok, accept;
    logic [N-1:0]  new_vec;

    assign wr_ok     = write_enable && (int'(write_address) < N);
    assign ld_ok     = load_enable && (int'(load_address) < N);
    assign bank_full = (count_q == CW'(N));
    assign accept    = swap_req && bank_full;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            logic [WIDTH-1:0] b0_q, b1_q;
            logic             valid_q;
            logic             wr_hit, ld_hit;

            assign wr_hit = wr_ok && (write_address == AW'(gi));
            assign ld_hit = ld_ok && (load_address == AW'(gi));

            // Writes target the bank not selected as input; an acceptance-cycle
            // write therefore lands in the bank that becomes the new input bank.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b0_q    <= '0;
                    b1_q    <= '0;
                    valid_q <= 1'b0;
                end else begin
                    if (bank_sel_q) begin
                        if (ld_hit) b1_q <= load_data;
                        if (wr_hit) b0_q <= in_data;
                    end else begin
                        if (ld_hit) b0_q <= load_data;
                        if (wr_hit) b1_q <= in_data;
                    end
                    if (accept)      valid_q <= 1'b0;
                    else if (wr_hit) valid_q <= 1'b1;
                end
            end

            assign new_vec[gi] = wr_hit && !valid_q;
            assign out_data[gi*WIDTH +: WIDTH] = bank_sel_q ? b1_q : b0_q;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        layer_d = layer_q;
        done_d  = 1'b0;
        err_d   = err_q | (write_enable && !wr_ok) | (load_enable && !ld_ok);
        if (accept) begin
            count_d = '0;
            if (layer_q == LW'(LAYERS - 1)) begin
                layer_d = '0;
                done_d  = 1'b1;
            end else begin
                layer_d = layer_q + 1'b1;
            end
        end else if (|new_vec) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            layer_q    <= '0;
            bank_sel_q <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            layer_q    <= layer_d;
            bank_sel_q <= bank_sel_q ^ accept;
            ack_q      <= accept;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign swap_ack      = ack_q;
    assign done          = done_q;
    assign addr_err      = err_q;
    assign bank_sel      = bank_sel_q;
    assign layer_idx     = layer_q;
    assign written_count = count_q;
endmodule

// File: tb/tb_layer_buffer.sv
// Self-checking bench for layer_buffer: directed scenarios plus random traffic,
// compared every cycle against a bank/valid-set model of the buffer.
module tb_layer_buffer;
    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           we, le, swap_req;
    logic [1:0]     wa, la;
    logic [W-1:0]   wd, ld;
    logic           swap_ack, bank_full, bank_sel, done, addr_err;
    logic [N*W-1:0] out_data;
    logic [2:0]     wc;
    logic [1:0]     layer_idx;

    logic           s_we, s_le;
    logic [1:0]     s_wa, s_la;
    logic [W-1:0]   s_wd, s_ld;
    logic           s_ack, s_full, s_sel, s_done, s_err;
    logic [3*W-1:0] s_out;
    logic [1:0]     s_wc;
    logic [1:0]     s_layer;

    layer_buffer #(.N(N), .WIDTH(W), .LAYERS(L)) dut (
        .clk(clk), .rst(rst),
        .write_enable(we), .write_address(wa), .in_data(wd),
        .load_enable(le), .load_address(la), .load_data(ld),
        .swap_req(swap_req), .swap_ack(swap_ack), .out_data(out_data),
        .written_count(wc), .bank_full(bank_full), .bank_sel(bank_sel),
        .layer_idx(layer_idx), .done(done), .addr_err(addr_err)
    );

    layer_buffer #(.N(3), .WIDTH(W), .LAYERS(L)) dut3 (
        .clk(clk), .rst(rst),
        .write_enable(s_we), .write_address(s_wa), .in_data(s_wd),
        .load_enable(s_le), .load_address(s_la), .load_data(s_ld),
        .swap_req(1'b0), .swap_ack(s_ack), .out_data(s_out),
        .written_count(s_wc), .bank_full(s_full), .bank_sel(s_sel),
        .layer_idx(s_layer), .done(s_done), .addr_err(s_err)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: two banks, a set of written entries, role index, layer counter.
    logic [W-1:0] mbank [2][N];
    bit   [N-1:0] mvalid;
    int           msel, mlayer;
    bit           mack, mdone, merr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount(input bit [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) mbank[b][i] = '0;
        mvalid = '0; msel = 0; mlayer = 0; mack = 0; mdone = 0; merr = 0;
    endtask

    task automatic model_step();
        bit full, acc;
        full = (popcount(mvalid) == N);
        acc  = swap_req && full;
        if (we) mbank[1 - msel][wa] = wd;
        if (le) mbank[msel][la] = ld;
        mack  = acc;
        mdone = 0;
        if (acc) begin
            msel   = 1 - msel;
            mvalid = '0;
            mlayer = mlayer + 1;
            if (mlayer == L) begin
                mlayer = 0;
                mdone  = 1;
            end
        end else if (we) begin
            mvalid[wa] = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [N*W-1:0] exp_out;
        for (int i = 0; i < N; i++) exp_out[i*W +: W] = mbank[msel][i];
        chk("out_data", 64'(out_data), 64'(exp_out));
        chk("written_count", 64'(wc), 64'(popcount(mvalid)));
        chk("bank_full", 64'(bank_full), 64'(popcount(mvalid) == N));
        chk("bank_sel", 64'(bank_sel), 64'(msel));
        chk("layer_idx", 64'(layer_idx), 64'(mlayer));
        chk("swap_ack", 64'(swap_ack), 64'(mack));
        chk("done", 64'(done), 64'(mdone));
        chk("addr_err", 64'(addr_err), 64'(merr));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic write(input int a, input int d);
        we = 1'b1; wa = 2'(a); wd = W'(d);
        cyc();
        we = 1'b0;
    endtask

    int acks;

    initial begin
        rst = 1'b1; we = 0; le = 0; swap_req = 0; wa = 0; la = 0; wd = 0; ld = 0;
        s_we = 0; s_le = 0; s_wa = 0; s_la = 0; s_wd = 0; s_ld = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("s_addr_err_reset", 64'(s_err), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Basic load / fill / swap
        for (int i = 0; i < N; i++) begin
            le = 1'b1; la = 2'(i); ld = W'(i + 1);
            cyc();
        end
        le = 1'b0;
        chk("load_out", 64'(out_data), 64'h0004_0003_0002_0001);
        for (int i = 0; i < N; i++) write(i, (i + 1) * 10);
        chk("full_after_4", 64'(bank_full), 64'd1);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("swap_ack_1", 64'(swap_ack), 64'd1);
        chk("swap_out", 64'(out_data), 64'h0028_001E_0014_000A);
        chk("swap_sel", 64'(bank_sel), 64'd1);
        chk("swap_count", 64'(wc), 64'd0);
        cyc();
        chk("ack_one_cycle", 64'(swap_ack), 64'd0);

        // Overwrite counts once, last value wins
        write(1, 5);
        write(1, 9);
        chk("overwrite_count", 64'(wc), 64'd1);
        write(0, $urandom);
        write(2, $urandom);
        write(3, $urandom);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("overwrite_val", 64'(out_data[1*W +: W]), 64'd9);
        chk("layer_after_2", 64'(layer_idx), 64'd2);
        chk("no_done_2", 64'(done), 64'd0);

        // Early request waits for the bank to fill, then acks exactly once
        write(0, 100); write(1, 101); write(2, 102);
        swap_req = 1'b1;
        cyc();
        chk("early_no_ack", 64'(swap_ack), 64'd0);
        write(3, 103);
        chk("early_full_no_ack", 64'(swap_ack), 64'd0);
        cyc();
        chk("early_ack", 64'(swap_ack), 64'd1);
        chk("done_third", 64'(done), 64'd1);
        chk("layer_wrap", 64'(layer_idx), 64'd0);
        acks = 0;
        repeat (5) begin
            cyc();
            acks += int'(swap_ack);
        end
        chk("held_req_acks", 64'(acks), 64'd0);
        swap_req = 1'b0;

        // Asynchronous reset mid-fill
        write(0, 1); write(1, 2);
        chk("midfill_count", 64'(wc), 64'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("reset_out_zero", 64'(out_data), 64'd0);
        @(negedge clk) rst = 1'b0;
        write(0, 77);
        chk("first_write_after_rst", 64'(wc), 64'd1);

        // Random traffic, including writes/loads in acceptance cycles
        for (int t = 0; t < 400; t++) begin
            we = ($urandom_range(0, 3) != 0); wa = 2'($urandom_range(0, 3)); wd = W'($urandom);
            le = ($urandom_range(0, 3) == 0); la = 2'($urandom_range(0, 3)); ld = W'($urandom);
            swap_req = ($urandom_range(0, 2) == 0);
            cyc();
        end
        we = 0; le = 0; swap_req = 0;

        // Out-of-range addresses on an N=3 instance
        s_le = 1'b1; s_la = 2'd0; s_ld = 16'h0011;
        cyc();
        s_le = 1'b0;
        chk("s_load_ok", 64'(s_out), 64'h11);
        chk("s_no_err", 64'(s_err), 64'd0);
        s_we = 1'b1; s_wa = 2'd3; s_wd = 16'h0055;
        s_le = 1'b1; s_la = 2'd3; s_ld = 16'h0099;
        cyc();
        s_we = 1'b0; s_le = 1'b0;
        chk("s_bad_no_change", 64'(s_out), 64'h11);
        chk("s_bad_no_count", 64'(s_wc), 64'd0);
        chk("s_err_set", 64'(s_err), 64'd1);
        repeat (3) cyc();
        chk("s_err_sticky", 64'(s_err), 64'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("s_err_cleared", 64'(s_err), 64'd0);
        chk("s_out_cleared", 64'(s_out), 64'd0);
        @(negedge clk) rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
